clk_divider_prog: RTL

Programmable clock divider: a successor to the fixed divide-by-7 counter. Divides `clk` by any runtime divisor N in [2, 2^WIDTH−1] and produces `o_div_clk`. Even N always gives 50% duty; odd N gives 50% duty via a negedge half-cycle extension when that feature is compiled in. New divisors arrive over a valid/ready handshake and take effect only at a period boundary, so the output never glitches. The block sits in the clock-generation area and feeds downstream logic needing a slow derived clock or a period-end strobe.

---
 rtl/clk_divider_prog.sv | 113 +++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: divides clk by a runtime divisor N (2..2^WIDTH-1).
// Define CLKDIV_ODD_DUTY_EN to build the negedge flop that gives odd N a 50% duty.
module clk_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  output logic             o_div_err,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_div_clk
);

  if (WIDTH < 2) begin : g_bad_width
    $error("clk_divider_prog: WIDTH must be at least 2");
  end
  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
    $error("clk_divider_prog: DEFAULT_DIV must be in 2..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_div_q;
  logic             pend_q;
  logic             en_q;
  logic             pos_q;
  logic             err_q;

  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] half_next;
  logic             count_end;
  logic             xfer;
  logic             div_bad;
  logic             apply;

  // Divisor handshake: a transfer happens on a posedge with i_div_valid && o_div_ready.
  // o_div_ready is low exactly while a legal divisor waits in the pending register.
  assign o_div_ready = !pend_q;
  assign xfer        = i_div_valid && !pend_q;
  assign div_bad     = (i_div < TWO);
  assign count_end   = i_enable && (count_q == div_q - ONE);
  assign apply       = pend_q && (count_end || !i_enable);

  always_comb begin
    div_next = div_q;
    if (apply) begin
      div_next = pend_div_q;
    end
    // A fresh enable restarts the period at count 0 rather than continuing.
    if (!i_enable || !en_q || count_end) begin
      count_next = '0;
    end else begin
      count_next = count_q + ONE;
    end
    half_next = div_next >> 1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      div_q      <= DEF_DIV;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
      pos_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q <= count_next;
      div_q   <= div_next;
      en_q    <= i_enable;
      pos_q   <= i_enable && (count_next < half_next);
      err_q   <= xfer && div_bad;
      if (apply) begin
        pend_q <= 1'b0;
      end else if (xfer && !div_bad) begin
        pend_q     <= 1'b1;
        pend_div_q <= i_div;
      end
    end
  end

  assign o_count     = count_q;
  assign o_count_end = count_end;
  assign o_div_err   = err_q;

`ifdef CLKDIV_ODD_DUTY_EN
  // Half-cycle extension of the high phase; only odd divisors use it.
  logic neg_q;

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q && div_q[0];
    end
  end

  assign o_div_clk = pos_q | neg_q;
`else
  assign o_div_clk = pos_q;
`endif

endmodule
